// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FP calculator datapath (divider and multiplier).
package fp_pkg;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        fp_class_t        cls;
    } fp_dec_t;
endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface fp_div_seq_if;
    import fp_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] in1;
    logic [FP_W-1:0] in2;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] out;

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out
    );

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational decode of one single-precision operand; subnormals read as signed zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] op,
    output fp_dec_t         dec
);
    logic [EXP_W-1:0] exp_c;
    logic [MAN_W-1:0] man_c;

    assign exp_c = op[FP_W-2 -: EXP_W];
    assign man_c = op[MAN_W-1:0];

    always_comb begin
        dec.sign = op[FP_W-1];
        dec.exp  = exp_c;
        dec.man  = man_c;
        dec.cls  = NORM;
        if (exp_c == '0) begin
            dec.cls = ZERO;
            dec.man = '0;
        end else if (exp_c == '1) begin
            dec.cls = (man_c == '0) ? INF : NAN;
        end
    end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: restoring division, one quotient bit per clock,
// round-to-nearest-even, valid/ready on both sides.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_div_seq_if.slave  bus
);
    localparam int unsigned M_W   = MAN_W + 1;
    localparam int unsigned R_W   = M_W + 1;
    localparam int unsigned Q_W   = M_W + 2;
    localparam int unsigned E_W   = 10;
    localparam int unsigned ITERS = Q_W;

    fp_dec_t da, db;
    fp_classify u_cls_a (.op(bus.in1), .dec(da));
    fp_classify u_cls_b (.op(bus.in2), .dec(db));

    state_t                state;
    logic                  sign_q;
    logic [R_W-1:0]        rem_q;
    logic [M_W-1:0]        mb_q;
    logic [Q_W-1:0]        q_q;
    logic signed [E_W-1:0] e_q;
    logic [4:0]            cnt_q;
    logic [FP_W-1:0]       out_q;
    logic                  out_valid_q;
    logic                  in_ready_q;

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

    // Special-operand result, valid whenever special_c is set
    logic            sgn_c;
    logic            special_c;
    logic [FP_W-1:0] special_res_c;

    always_comb begin
        sgn_c         = da.sign ^ db.sign;
        special_c     = 1'b1;
        special_res_c = QNAN;
        if (da.cls == NAN || db.cls == NAN) begin
            special_res_c = QNAN;
        end else if ((da.cls == ZERO && db.cls == ZERO) || (da.cls == INF && db.cls == INF)) begin
            special_res_c = QNAN;
        end else if (db.cls == ZERO || da.cls == INF) begin
            special_res_c = {sgn_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (da.cls == ZERO || db.cls == INF) begin
            special_res_c = {sgn_c, {(FP_W-1){1'b0}}};
        end else begin
            special_c = 1'b0;
        end
    end

    // Pre-normalise so the quotient always lands in [1,2)
    logic [M_W-1:0]        ma_c, mb_c;
    logic                  lt_c;
    logic [R_W-1:0]        rem_init_c;
    logic signed [E_W-1:0] e_init_c;

    always_comb begin
        ma_c       = {1'b1, da.man};
        mb_c       = {1'b1, db.man};
        lt_c       = ma_c < mb_c;
        rem_init_c = lt_c ? {ma_c, 1'b0} : {1'b0, ma_c};
        e_init_c   = E_W'(da.exp) - E_W'(db.exp) + E_W'(BIAS) - E_W'(lt_c);
    end

    logic           ge_c;
    logic [M_W-1:0] diff_c;

    always_comb begin
        ge_c   = rem_q >= {1'b0, mb_q};
        diff_c = ge_c ? M_W'(rem_q - {1'b0, mb_q}) : rem_q[M_W-1:0];
    end

    // Guard = q[1], round = q[0], sticky = leftover remainder
    logic                  round_up_c;
    logic [M_W:0]          mant_c;
    logic signed [E_W-1:0] e_r_c;
    logic [FP_W-1:0]       round_res_c;

    always_comb begin
        round_up_c = q_q[1] & (q_q[0] | (|rem_q) | q_q[2]);
        mant_c     = {1'b0, q_q[Q_W-1:2]} + (M_W+1)'(round_up_c);
        e_r_c      = e_q + E_W'(mant_c[M_W]);
        if (e_r_c >= 10'sd255) begin
            round_res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (e_r_c <= 10'sd0) begin
            round_res_c = {sign_q, {(FP_W-1){1'b0}}};
        end else begin
            round_res_c = {sign_q, e_r_c[EXP_W-1:0], mant_c[MAN_W-1:0]};
        end
    end

    // out_valid rises one edge after DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sign_q     <= sgn_c;
                        in_ready_q <= 1'b0;
                        if (special_c) begin
                            out_q <= special_res_c;
                            state <= DONE;
                        end else begin
                            rem_q <= rem_init_c;
                            mb_q  <= mb_c;
                            q_q   <= '0;
                            e_q   <= e_init_c;
                            cnt_q <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_q   <= {q_q[Q_W-2:0], ge_c};
                    rem_q <= {diff_c, 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITERS - 1)) state <= ROUND;
                end
                ROUND: begin
                    out_q <= round_res_c;
                    state <= DONE;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed corner cases plus random operands
// compared against an integer long-division reference.
module tb_fp_div_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    fp_div_seq_if bus();

    fp_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact quotient by integer division, then round-to-nearest-even
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int      ea, eb, e, n;
        longint  fa, fb, ma, mb, num, qq, rr, m, drop, half;
        logic    s;
        bit      a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        ea = int'(a[30:23]);  eb = int'(b[30:23]);
        fa = longint'(a[22:0]); fb = longint'(b[22:0]);
        s  = a[31] ^ b[31];
        a_zero = (ea == 0);   b_zero = (eb == 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
        if (b_zero || a_inf) return {s, 8'hFF, 23'h0};
        if (a_zero || b_inf) return {s, 31'h0};
        ma  = fa + (64'd1 << 23);
        mb  = fb + (64'd1 << 23);
        num = ma << 30;
        qq  = num / mb;
        rr  = num % mb;
        e   = ea - eb + 127;
        if (qq >= (64'd1 << 30)) n = 7;
        else begin n = 6; e = e - 1; end
        m    = qq >> n;
        drop = qq & ((64'd1 << n) - 1);
        half = 64'd1 << (n - 1);
        if (drop > half || (drop == half && (rr != 0 || (m & 1) != 0))) m = m + 1;
        if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e = e + 1; end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(m)};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!bus.in_ready) begin check({tag, "_rdy_timeout"}, 32'(bus.in_ready), 32'd1); return; end
        bus.in_valid = 1'b1;
        bus.in1 = a;
        bus.in2 = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in1 = $urandom();
        bus.in2 = $urandom();
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) begin check({tag, "_valid_timeout"}, 32'(bus.out_valid), 32'd1); return; end
        if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, bus.out, expv);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a, b;
        int lat;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out", bus.out, 32'h0);
        rst = 1'b0;

        run_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28);
        run_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 28);
        run_op("m7_div_3p5", 32'hC0E0_0000, 32'h4060_0000, 32'hC000_0000, 28);
        run_op("x_div_zero", 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1);
        run_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1);
        run_op("inf_div_inf", 32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1);
        run_op("x_div_nan", 32'h44FC_7333, 32'hFF80_0001, 32'h7FC0_0000, 1);
        run_op("zero_div_x", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1);
        run_op("x_div_inf", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1);
        run_op("subn_div_x", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1);
        run_op("overflow", 32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 28);
        run_op("underflow", 32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 28);

        // Backpressure: result held, no accept while DONE
        bus.in_valid = 1'b1;
        bus.in1 = 32'h40C0_0000;
        bus.in2 = 32'h4000_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("bp_first", bus.out, 32'h4040_0000);
        bus.in_valid = 1'b1;
        bus.in1 = 32'h3F80_0000;
        bus.in2 = 32'h4040_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_out", bus.out, 32'h4040_0000);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release", 32'(bus.out_valid), 32'd0);
        check("bp_idle", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_accept", 32'(bus.in_ready), 32'd1);

        // Reset while iterating aborts the operation
        bus.in_valid = 1'b1;
        bus.in1 = 32'h3F80_0000;
        bus.in2 = 32'h4040_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28);

        // Reference self-consistency on the directed values
        check("ref_one_third", ref_div(32'h3F80_0000, 32'h4040_0000), 32'h3EAA_AAAB);

        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) begin
                a = $urandom();
                b = $urandom();
            end else begin
                a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom())};
                b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom())};
            end
            run_op("rand", a, b, ref_div(a, b), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
